// File: rtl/score_to_digits.sv
// Registered binary-to-BCD converter for a 14-bit score.
// Scores above 9999 saturate to 9999 before conversion.
module score_to_digits (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] score,
  output logic [3:0]  thousands,
  output logic [3:0]  hundreds,
  output logic [3:0]  tens,
  output logic [3:0]  ones
);

  logic [13:0] satScore;
  logic [15:0] bcdD;
  logic [15:0] bcdQ;

  assign satScore = (score > 14'd9999) ? 14'd9999 : score;

  // Double-dabble: before each shift, add 3 to any BCD digit that is 5 or more.
  always_comb begin
    bcdD = 16'd0;
    for (int i = 13; i >= 0; i--) begin
      for (int j = 0; j < 4; j++) begin
        if (bcdD[4*j +: 4] >= 4'd5) begin
          bcdD[4*j +: 4] = bcdD[4*j +: 4] + 4'd3;
        end
      end
      bcdD = {bcdD[14:0], satScore[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcdQ <= 16'd0;
    end else begin
      bcdQ <= bcdD;
    end
  end

  assign thousands = bcdQ[15:12];
  assign hundreds  = bcdQ[11:8];
  assign tens      = bcdQ[7:4];
  assign ones      = bcdQ[3:0];

endmodule

// File: tb/tb_score_to_digits.sv
// Self-checking bench for score_to_digits: directed cases, full sweep and
// randomized scores with random resets, compared against a div/mod model.
module tb_score_to_digits;

  logic        clk;
  logic        rst;
  logic [13:0] score;
  logic [3:0]  thousands;
  logic [3:0]  hundreds;
  logic [3:0]  tens;
  logic [3:0]  ones;

  int assertCount = 0;
  int failCount   = 0;

  score_to_digits dut (
    .clk       (clk),
    .rst       (rst),
    .score     (score),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits of min(value, 9999), packed one digit per nibble.
  function automatic logic [15:0] refDigits(input int value);
    int v;
    v = (value > 9999) ? 9999 : value;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] observedDigits();
    return {thousands, hundreds, tens, ones};
  endfunction

  // Drive one score (and reset) and let exactly one rising edge capture it.
  task automatic applyStimulus(input logic rstVal, input int scoreVal);
    rst   = rstVal;
    score = 14'(scoreVal);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkDigitRange(input string tag);
    logic [15:0] d;
    d = observedDigits();
    checkOutput(tag, {12'd0, 1'b0, d[15:12] <= 4'd9, d[11:8] <= 4'd9,
                      (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9)}, 16'h0007);
  endtask

  int boundaryVals [9] = '{0, 9, 10, 999, 1000, 9999, 10000, 12345, 16383};

  initial begin
    rst   = 1'b1;
    score = 14'd0;

    // Reset dominates a pending score, then one clean edge converts it.
    applyStimulus(1'b1, 1234);
    checkOutput("reset_1234", observedDigits(), 16'h0000);
    applyStimulus(1'b0, 1234);
    checkOutput("after_reset_1234", observedDigits(), 16'h1234);

    foreach (boundaryVals[k]) begin
      applyStimulus(1'b0, boundaryVals[k]);
      checkOutput($sformatf("boundary_%0d", boundaryVals[k]), observedDigits(),
                  refDigits(boundaryVals[k]));
    end

    // Back-to-back scores on consecutive edges, also sampled mid-cycle.
    applyStimulus(1'b0, 4321);
    checkOutput("b2b_4321", observedDigits(), 16'h4321);
    score = 14'd5;
    @(negedge clk);
    checkOutput("b2b_4321_hold", observedDigits(), 16'h4321);
    @(posedge clk);
    #1;
    checkOutput("b2b_5", observedDigits(), 16'h0005);

    // Holding the input holds the output.
    applyStimulus(1'b0, 5);
    checkOutput("hold_5", observedDigits(), 16'h0005);

    applyStimulus(1'b1, 8765);
    checkOutput("midstream_reset", observedDigits(), 16'h0000);
    applyStimulus(1'b0, 8765);
    checkOutput("midstream_release", observedDigits(), 16'h8765);

    for (int s = 0; s <= 10000; s++) begin
      applyStimulus(1'b0, s);
      checkOutput($sformatf("sweep_%0d", s), observedDigits(), refDigits(s));
      checkDigitRange($sformatf("sweep_range_%0d", s));
    end

    for (int n = 0; n < 500; n++) begin
      int   sv;
      logic rv;
      sv = int'($urandom_range(16383, 0));
      rv = ($urandom_range(15, 0) == 0);
      applyStimulus(rv, sv);
      checkOutput($sformatf("rand_%0d_rst%0d", sv, rv), observedDigits(),
                  rv ? 16'h0000 : refDigits(sv));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/score_to_digits.md
SCORE_TO_DIGITS -- requirements
Module: score_to_digits

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Port score, input, 14 bits: unsigned binary score, range 0..16383.
REQ-005 Port thousands, output, 4 bits: BCD thousands digit, 0..9, registered.
REQ-006 Port hundreds, output, 4 bits: BCD hundreds digit, 0..9, registered.
REQ-007 Port tens, output, 4 bits: BCD tens digit, 0..9, registered.
REQ-008 Port ones, output, 4 bits: BCD ones digit, 0..9, registered.
REQ-009 The block SHALL have no parameters and no other ports.

Function
REQ-010 The block SHALL convert score to four decimal digits such that 1000*thousands + 100*hundreds + 10*tens + ones = min(score, 9999).
REQ-011 Scores of 10000..16383 SHALL saturate: the outputs are 9,9,9,9.
REQ-012 The conversion SHALL be exact binary-to-BCD, implemented as a shift-and-add-3 (double-dabble) network or an equivalent divide/modulo network; no lookup truncation.
REQ-013 Each digit output SHALL never exceed 9 under any input.
REQ-014 Latency SHALL be exactly one clock: the outputs after rising edge k reflect the score sampled at edge k.
REQ-015 The block SHALL accept a new score every cycle (throughput 1/clock) with no handshake and no stall.
REQ-016 All four digit registers SHALL update together on the same edge; no mixed old/new digits are visible.
REQ-017 Holding score constant SHALL hold the outputs constant.
REQ-018 Output values SHALL depend only on score sampled at the last edge, not on any earlier history.
REQ-019 The converter SHALL produce no X or Z outputs for any 14-bit score input after the first reset.

Reset
REQ-020 When rst=1 at a rising edge, thousands, hundreds, tens and ones SHALL all become 0 on that edge, regardless of score.
REQ-021 Reset SHALL take priority over conversion on the same edge.
REQ-022 On the first edge with rst=0, the outputs SHALL reflect the score sampled on that edge (normal one-cycle latency).
REQ-023 Asserting rst mid-stream SHALL discard the pending conversion; there is no other state to clear.

Verification
REQ-024 Reset: rst=1, score=1234, one edge -> all outputs 0; then rst=0, one edge -> 1,2,3,4.
REQ-025 Exhaustive sweep: after reset, apply score=0..10000, one value per clock; each output one clock later matches decimal digits of min(score,9999), and each digit is <=9.
REQ-026 Boundaries: score=0 -> 0,0,0,0; 9 -> 0,0,0,9; 10 -> 0,0,1,0; 999 -> 0,9,9,9; 1000 -> 1,0,0,0; 9999 -> 9,9,9,9.
REQ-027 Saturation: score=10000, 12345 and 16383 -> 9,9,9,9 each, one clock later.
REQ-028 Latency/throughput: back-to-back scores 4321 then 5 on consecutive edges -> outputs 4,3,2,1 then 0,0,0,5 on the following consecutive edges, with no intermediate mixed value.
REQ-029 Reset mid-stream: score=8765 with rst=1 on the same edge -> 0,0,0,0; next edge with rst=0 and score=8765 -> 8,7,6,5.
